sync_aligner: RTL and testbench

SYNC_ALIGNER -- requirements
Module: sync_aligner

---
 rtl/sync_aligner.sv | 165 ++++++++++++++++
 tb/tb_sync_aligner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_aligner.sv
// rtl/sync_aligner.sv - aligns queued DVI pixels with the Homography CCD stream and flags coordinate mismatches
// Optional resync-on-mismatch flush: define SYNC_ALIGNER_RESYNC_EN.
module sync_aligner #(
    parameter int DEPTH = 3,
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int RW    = 5,
    parameter int GW    = 6,
    parameter int BW    = 5,
    parameter int CW    = 16
) (
    input  logic                        clk_25,
    input  logic                        rst,
    input  logic [XW+YW+23:0]           q,
    input  logic                        rdreq,
    input  logic [XW-1:0]               return_x,
    input  logic [YW-1:0]               return_y,
    input  logic [RW-1:0]               r,
    input  logic [GW-1:0]               g,
    input  logic [BW-1:0]               b,
    input  logic                        ready,
    input  logic                        clr_err,
    output logic                        val,
    output logic [XW-1:0]               sync_x,
    output logic [YW-1:0]               sync_y,
    output logic [RW-1:0]               dvi_r,
    output logic [GW-1:0]               dvi_g,
    output logic [BW-1:0]               dvi_b,
    output logic [RW-1:0]               ccd_r,
    output logic [GW-1:0]               ccd_g,
    output logic [BW-1:0]               ccd_b,
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic                        mismatch,
    output logic [CW-1:0]               mismatch_cnt,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = XW + YW + RW + GW + BW;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    localparam logic [0:0] ST_RUN = 1'b0;
`ifdef SYNC_ALIGNER_RESYNC_EN
    localparam logic [0:0] ST_FLUSH = 1'b1;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [0:0]    state;

    logic [EW-1:0] push_word;
    logic [EW-1:0] head;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [RW-1:0] head_r;
    logic [GW-1:0] head_g;
    logic [BW-1:0] head_b;

    logic run, full, empty;
    logic do_pop, do_push;
    logic ovf_ev, unf_ev, mm_ev;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Colour is truncated to the output channel widths at push time, keeping the MSBs.
    assign push_word = {q[XW+YW+23 -: XW], q[YW+23 -: YW],
                        q[23 -: RW], q[15 -: GW], q[7 -: BW]};

    assign head   = mem[rd_ptr];
    assign head_x = head[EW-1 -: XW];
    assign head_y = head[EW-XW-1 -: YW];
    assign head_r = head[RW+GW+BW-1 -: RW];
    assign head_g = head[GW+BW-1 -: GW];
    assign head_b = head[BW-1:0];

    assign run     = (state == ST_RUN);
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = run && ready && !empty;
    // A pop frees the head slot before the push lands, so a full FIFO can still accept.
    assign do_push = run && rdreq && (!full || do_pop);
    assign ovf_ev  = run && rdreq && full && !do_pop;
    assign unf_ev  = run && ready && empty;
    assign mm_ev   = do_pop && ((head_x != return_x) || (head_y != return_y));

    always_ff @(posedge clk_25) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            val          <= 1'b0;
            sync_x       <= '0;
            sync_y       <= '0;
            dvi_r        <= '0;
            dvi_g        <= '0;
            dvi_b        <= '0;
            ccd_r        <= '0;
            ccd_g        <= '0;
            ccd_b        <= '0;
            level        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            state        <= ST_RUN;
        end else begin
            val <= do_pop;
            if (do_pop) begin
                sync_x <= head_x;
                sync_y <= head_y;
                dvi_r  <= head_r;
                dvi_g  <= head_g;
                dvi_b  <= head_b;
                ccd_r  <= r;
                ccd_g  <= g;
                ccd_b  <= b;
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end

            overflow  <= ovf_ev | (overflow & ~clr_err);
            underflow <= unf_ev | (underflow & ~clr_err);
            mismatch  <= mm_ev | (mismatch & ~clr_err);
            if (mm_ev) begin
                if (clr_err) begin
                    mismatch_cnt <= CW'(1);
                end else if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
            end else if (clr_err) begin
                mismatch_cnt <= '0;
            end

`ifdef SYNC_ALIGNER_RESYNC_EN
            if (state == ST_FLUSH) begin
                level  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                state  <= ST_RUN;
            end else if (mm_ev) begin
                state <= ST_FLUSH;
            end
`else
            state <= ST_RUN;
`endif
        end
    end
endmodule

// File: tb/tb_sync_aligner.sv
// tb/tb_sync_aligner.sv - table-driven self-checking bench for sync_aligner
module tb_sync_aligner;
    logic        clk_25 = 1'b0;
    logic        rst;
    logic [43:0] q;
    logic        rdreq, ready, clr_err;
    logic [9:0]  return_x, return_y;
    logic [4:0]  r, b;
    logic [5:0]  g;

    logic        val, mismatch, overflow, underflow;
    logic [9:0]  sync_x, sync_y;
    logic [4:0]  dvi_r, dvi_b, ccd_r, ccd_b;
    logic [5:0]  dvi_g, ccd_g;
    logic [1:0]  level;
    logic [15:0] mismatch_cnt;

    logic        c2_val, c2_mismatch, c2_overflow, c2_underflow;
    logic [9:0]  c2_sync_x, c2_sync_y;
    logic [4:0]  c2_dvi_r, c2_dvi_b, c2_ccd_r, c2_ccd_b;
    logic [5:0]  c2_dvi_g, c2_ccd_g;
    logic [1:0]  c2_level;
    logic [1:0]  c2_cnt;

    always #20 clk_25 = ~clk_25;

    sync_aligner dut (
        .clk_25(clk_25), .rst(rst), .q(q), .rdreq(rdreq),
        .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
        .ready(ready), .clr_err(clr_err), .val(val),
        .sync_x(sync_x), .sync_y(sync_y),
        .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
        .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b),
        .level(level), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt),
        .overflow(overflow), .underflow(underflow)
    );

    sync_aligner #(.CW(2)) dut_cw2 (
        .clk_25(clk_25), .rst(rst), .q(q), .rdreq(rdreq),
        .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
        .ready(ready), .clr_err(clr_err), .val(c2_val),
        .sync_x(c2_sync_x), .sync_y(c2_sync_y),
        .dvi_r(c2_dvi_r), .dvi_g(c2_dvi_g), .dvi_b(c2_dvi_b),
        .ccd_r(c2_ccd_r), .ccd_g(c2_ccd_g), .ccd_b(c2_ccd_b),
        .level(c2_level), .mismatch(c2_mismatch), .mismatch_cnt(c2_cnt),
        .overflow(c2_overflow), .underflow(c2_underflow)
    );

    typedef struct packed {
        logic [9:0] sx, sy;
        logic [4:0] dr; logic [5:0] dg; logic [4:0] db;
        logic [4:0] cr; logic [5:0] cg; logic [4:0] cb;
    } dat_t;

    typedef struct packed {
        logic val; dat_t d; logic [1:0] lvl; logic mm; logic [15:0] cnt; logic ovf; logic unf;
    } exp_t;

    typedef struct packed {
        logic rdreq; logic [9:0] qx, qy; logic [7:0] r8, g8, b8;
        logic ready; logic [9:0] rx, ry; logic [4:0] r; logic [5:0] g; logic [4:0] b;
        logic clr;
    } in_t;

    typedef struct packed { in_t i; exp_t e; } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic in_t f_push(int x, int y, int r8v, int g8v, int b8v);
        in_t v = '0;
        v.rdreq = 1'b1; v.qx = 10'(x); v.qy = 10'(y);
        v.r8 = 8'(r8v); v.g8 = 8'(g8v); v.b8 = 8'(b8v);
        return v;
    endfunction

    function automatic in_t f_pop(int x, int y, int rv, int gv, int bv);
        in_t v = '0;
        v.ready = 1'b1; v.rx = 10'(x); v.ry = 10'(y);
        v.r = 5'(rv); v.g = 6'(gv); v.b = 5'(bv);
        return v;
    endfunction

    function automatic in_t f_clr();
        in_t v = '0;
        v.clr = 1'b1;
        return v;
    endfunction

    function automatic dat_t f_d(int sx, int sy, int dr, int dg, int db, int cr, int cg, int cb);
        dat_t d;
        d.sx = 10'(sx); d.sy = 10'(sy);
        d.dr = 5'(dr); d.dg = 6'(dg); d.db = 5'(db);
        d.cr = 5'(cr); d.cg = 6'(cg); d.cb = 5'(cb);
        return d;
    endfunction

    function automatic exp_t f_e(logic v, dat_t d, int lvl, logic mm, int cnt, logic ovf, logic unf);
        exp_t e;
        e.val = v; e.d = d; e.lvl = 2'(lvl); e.mm = mm; e.cnt = 16'(cnt);
        e.ovf = ovf; e.unf = unf;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input in_t v);
        rdreq = v.rdreq; q = {v.qx, v.qy, v.r8, v.g8, v.b8};
        ready = v.ready; return_x = v.rx; return_y = v.ry;
        r = v.r; g = v.g; b = v.b; clr_err = v.clr;
    endtask

    task automatic check_all(input string t, input exp_t e);
        chk({t, ".val"}, 32'(val), 32'(e.val));
        chk({t, ".sync_x"}, 32'(sync_x), 32'(e.d.sx));
        chk({t, ".sync_y"}, 32'(sync_y), 32'(e.d.sy));
        chk({t, ".dvi_r"}, 32'(dvi_r), 32'(e.d.dr));
        chk({t, ".dvi_g"}, 32'(dvi_g), 32'(e.d.dg));
        chk({t, ".dvi_b"}, 32'(dvi_b), 32'(e.d.db));
        chk({t, ".ccd_r"}, 32'(ccd_r), 32'(e.d.cr));
        chk({t, ".ccd_g"}, 32'(ccd_g), 32'(e.d.cg));
        chk({t, ".ccd_b"}, 32'(ccd_b), 32'(e.d.cb));
        chk({t, ".level"}, 32'(level), 32'(e.lvl));
        chk({t, ".mismatch"}, 32'(mismatch), 32'(e.mm));
        chk({t, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(e.cnt));
        chk({t, ".overflow"}, 32'(overflow), 32'(e.ovf));
        chk({t, ".underflow"}, 32'(underflow), 32'(e.unf));
    endtask

    task automatic run1(input string t, input in_t v, input exp_t e);
        apply(v);
        @(posedge clk_25);
        #1;
        check_all(t, e);
    endtask

    initial begin : main
        dat_t D0, D1, DA, DB, DC, DM, DD, D5, cur_d;
        in_t  IDLE, PA, PB, PC, PD;
        logic cur_mm;
        int   cur_cnt;

        IDLE = '0;
        D0 = '0;
        D1 = f_d(5, 7, 'h1F, 'h20, 'h01, 3, 4, 5);
        DA = f_d(1, 2, 2, 3, 4, 1, 1, 1);
        DB = f_d(3, 4, 5, 6, 7, 1, 1, 1);
        DC = f_d(6, 8, 8, 9, 'hA, 1, 1, 1);
        DM = f_d(10, 3, 0, 0, 0, 0, 0, 0);
        DD = f_d(9, 9, 'h1F, 'h3F, 'h1F, 1, 1, 1);
        D5 = f_d(5, 7, 'h1F, 'h20, 'h01, 2, 2, 2);
        PA = f_push(1, 2, 'h10, 'h0C, 'h20);
        PB = f_push(3, 4, 'h28, 'h18, 'h38);
        PC = f_push(6, 8, 'h40, 'h24, 'h50);
        PD = f_push(9, 9, 'hFF, 'hFF, 'hFF);

        tbl.push_back('{IDLE, f_e(0, D0, 0, 0, 0, 0, 0)});
        tbl.push_back('{f_push(5, 7, 'hFF, 'h80, 'h08), f_e(0, D0, 1, 0, 0, 0, 0)});
        tbl.push_back('{f_pop(5, 7, 3, 4, 5), f_e(1, D1, 0, 0, 0, 0, 0)});
        tbl.push_back('{IDLE, f_e(0, D1, 0, 0, 0, 0, 0)});
        tbl.push_back('{f_pop(5, 7, 9, 9, 9), f_e(0, D1, 0, 0, 0, 0, 1)});
        tbl.push_back('{f_clr(), f_e(0, D1, 0, 0, 0, 0, 0)});
        tbl.push_back('{PA, f_e(0, D1, 1, 0, 0, 0, 0)});
        tbl.push_back('{PB, f_e(0, D1, 2, 0, 0, 0, 0)});
        tbl.push_back('{PC, f_e(0, D1, 3, 0, 0, 0, 0)});
        tbl.push_back('{PD, f_e(0, D1, 3, 0, 0, 1, 0)});
        tbl.push_back('{f_pop(1, 2, 1, 1, 1), f_e(1, DA, 2, 0, 0, 1, 0)});
        tbl.push_back('{f_pop(3, 4, 1, 1, 1), f_e(1, DB, 1, 0, 0, 1, 0)});
        tbl.push_back('{f_pop(6, 8, 1, 1, 1), f_e(1, DC, 0, 0, 0, 1, 0)});
        tbl.push_back('{f_clr(), f_e(0, DC, 0, 0, 0, 0, 0)});
        tbl.push_back('{f_push(10, 3, 0, 0, 0), f_e(0, DC, 1, 0, 0, 0, 0)});
        tbl.push_back('{f_pop(11, 3, 0, 0, 0), f_e(1, DM, 0, 1, 1, 0, 0)});
        tbl.push_back('{IDLE, f_e(0, DM, 0, 1, 1, 0, 0)});
        for (int k = 2; k <= 5; k++) begin
            tbl.push_back('{f_push(10, 3, 0, 0, 0), f_e(0, DM, 1, 1, k - 1, 0, 0)});
            if (k % 2 == 0)
                tbl.push_back('{f_pop(10, 4, 0, 0, 0), f_e(1, DM, 0, 1, k, 0, 0)});
            else
                tbl.push_back('{f_pop(11, 3, 0, 0, 0), f_e(1, DM, 0, 1, k, 0, 0)});
            tbl.push_back('{IDLE, f_e(0, DM, 0, 1, k, 0, 0)});
        end

        apply(IDLE);
        rst = 1'b1;
        repeat (2) @(posedge clk_25);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run1($sformatf("v%0d", i), tbl[i].i, tbl[i].e);
        end

        chk("cw2_saturated", 32'(c2_cnt), 32'd3);
        run1("clr_cnt", f_clr(), f_e(0, DM, 0, 0, 0, 0, 0));
        chk("cw2_cleared", 32'(c2_cnt), 32'd0);

        run1("full_a", PA, f_e(0, DM, 1, 0, 0, 0, 0));
        run1("full_b", PB, f_e(0, DM, 2, 0, 0, 0, 0));
        run1("full_c", PC, f_e(0, DM, 3, 0, 0, 0, 0));
        run1("full_pp", PD | f_pop(1, 2, 1, 1, 1), f_e(1, DA, 3, 0, 0, 0, 0));
        run1("full_p1", f_pop(3, 4, 1, 1, 1), f_e(1, DB, 2, 0, 0, 0, 0));
        run1("full_p2", f_pop(6, 8, 1, 1, 1), f_e(1, DC, 1, 0, 0, 0, 0));
        run1("full_p3", f_pop(9, 9, 1, 1, 1), f_e(1, DD, 0, 0, 0, 0, 0));

        run1("empty_pp", f_push(5, 7, 'hFF, 'h80, 'h08) | f_pop(5, 7, 2, 2, 2),
             f_e(0, DD, 1, 0, 0, 0, 1));
        run1("empty_pop", f_pop(5, 7, 2, 2, 2), f_e(1, D5, 0, 0, 0, 0, 1));
        run1("empty_clr", f_clr(), f_e(0, D5, 0, 0, 0, 0, 0));

`ifdef SYNC_ALIGNER_RESYNC_EN
        run1("rs_a", PA, f_e(0, D5, 1, 0, 0, 0, 0));
        run1("rs_b", PB, f_e(0, D5, 2, 0, 0, 0, 0));
        run1("rs_c", PC, f_e(0, D5, 3, 0, 0, 0, 0));
        run1("rs_mm", f_pop(2, 2, 1, 1, 1), f_e(1, DA, 2, 1, 1, 0, 0));
        run1("rs_flush", PD, f_e(0, DA, 0, 1, 1, 0, 0));
        run1("rs_push", PA, f_e(0, DA, 1, 1, 1, 0, 0));
        run1("rs_drain", f_pop(1, 2, 1, 1, 1), f_e(1, DA, 0, 1, 1, 0, 0));
        cur_d = DA; cur_mm = 1'b1; cur_cnt = 1;
`else
        cur_d = D5; cur_mm = 1'b0; cur_cnt = 0;
`endif

        run1("pre_unf", f_pop(0, 0, 0, 0, 0), f_e(0, cur_d, 0, cur_mm, cur_cnt, 0, 1));
        run1("pre_a", PA, f_e(0, cur_d, 1, cur_mm, cur_cnt, 0, 1));
        run1("pre_b", PB, f_e(0, cur_d, 2, cur_mm, cur_cnt, 0, 1));
        apply(PC | f_pop(1, 2, 1, 1, 1));
        rst = 1'b1;
        @(posedge clk_25);
        #1;
        check_all("rst", f_e(0, D0, 0, 0, 0, 0, 0));
        chk("rst_cw2_cnt", 32'(c2_cnt), 32'd0);
        rst = 1'b0;
        run1("post_idle", IDLE, f_e(0, D0, 0, 0, 0, 0, 0));
        run1("post_unf", f_pop(1, 2, 1, 1, 1), f_e(0, D0, 0, 0, 0, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
